i2s_tx_serializer: RTL and testbench

Bit-clock-domain I2S transmitter for the chorus pedal's output path. It pops one 16-bit processed audio sample per frame from the first-word-fall-through (FWFT) read port of the DSP-to-I2S fast-to-slow CDC FIFO. It serializes the sample MSB-first, Philips I2S format, to the DAC, duplicating mono audio on left and right. It generates word select, frame strobes and underrun accounting.

---
 rtl/i2s_tx_serializer.sv | 132 +++++++++++++
 tb/tb_i2s_tx_serializer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter in the bit-clock domain: pops one FWFT sample per frame and sends
// it MSB-first on both channels, with word select, frame strobe and underrun accounting.
module i2s_tx_serializer #(
    parameter int unsigned PKT_WIDTH     = 16,
    parameter int unsigned SLOT_WIDTH    = 16,
    parameter int unsigned UNDERRUN_HOLD = 1
) (
    input  logic                 clkI2SBit_i,
    input  logic                 rstI2S_n_i,
    input  logic                 enable_i,
    input  logic [PKT_WIDTH-1:0] pktFifo_i,
    input  logic                 fifoEmpty_i,
    output logic                 fifoRdEn_o,
    output logic                 i2sLRCLK_o,
    output logic                 i2sSD_o,
    output logic                 frameStrobe_o,
    output logic                 underrun_o,
    output logic [7:0]           underrunCnt_o
);

    localparam int unsigned FrameLen = 2 * SLOT_WIDTH;
    localparam int unsigned PosW     = $clog2(FrameLen);

    localparam logic [PosW-1:0] PosLast   = PosW'(FrameLen - 1);
    localparam logic [PosW-1:0] PosSlot   = PosW'(SLOT_WIDTH);
    localparam logic [PosW-1:0] PosLrRise = PosW'(SLOT_WIDTH - 1);
    localparam logic [PosW-1:0] PosLrFall = PosW'(FrameLen - 2);

    typedef enum logic {StIdle, StRun} state_e;

    state_e                 state_q, state_d;
    logic [PosW-1:0]        pos_q, pos_d;
    logic [PKT_WIDTH-1:0]   tx_q, tx_d;
    logic                   sd_q, sd_d;
    logic                   lrclk_q, lrclk_d;
    logic                   strobe_q, strobe_d;
    logic                   underrun_q, underrun_d;
    logic [7:0]             cnt_q, cnt_d;

    logic                   load;
    logic                   running_d;
    logic [PosW-1:0]        slot_pos;
    logic [SLOT_WIDTH-1:0]  slot_word;
    logic [SLOT_WIDTH-1:0]  slot_shifted;

    always_comb begin
        load    = 1'b0;
        state_d = state_q;
        pos_d   = pos_q;
        case (state_q)
            StIdle: begin
                if (enable_i) begin
                    load    = 1'b1;
                    state_d = StRun;
                    pos_d   = '0;
                end
            end
            StRun: begin
                // Enable is only honoured on the closing cycle so frames are never cut short.
                if (pos_q == PosLast) begin
                    if (enable_i) begin
                        load  = 1'b1;
                        pos_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    pos_d = pos_q + PosW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                pos_d   = PosLast;
            end
        endcase

        fifoRdEn_o = load && !fifoEmpty_i && rstI2S_n_i;
        underrun_d = load && fifoEmpty_i;

        tx_d = tx_q;
        if (load) begin
            if (!fifoEmpty_i) begin
                tx_d = pktFifo_i;
            end else if (UNDERRUN_HOLD == 0) begin
                tx_d = '0;
            end
        end

        cnt_d = cnt_q;
        if (underrun_d && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end

        // Outputs are computed from next-cycle state so the registers line up with pos_q.
        running_d    = (state_d == StRun);
        slot_word    = SLOT_WIDTH'(tx_d) << (SLOT_WIDTH - PKT_WIDTH);
        slot_pos     = (pos_d < PosSlot) ? pos_d : (pos_d - PosSlot);
        slot_shifted = slot_word << slot_pos;
        sd_d         = running_d && slot_shifted[SLOT_WIDTH-1];
        lrclk_d      = running_d && (pos_d >= PosLrRise) && (pos_d <= PosLrFall);
        strobe_d     = running_d && (pos_d == '0);
    end

    always_ff @(posedge clkI2SBit_i or negedge rstI2S_n_i) begin
        if (!rstI2S_n_i) begin
            state_q    <= StIdle;
            pos_q      <= PosLast;
            tx_q       <= '0;
            sd_q       <= 1'b0;
            lrclk_q    <= 1'b0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            tx_q       <= tx_d;
            sd_q       <= sd_d;
            lrclk_q    <= lrclk_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
            cnt_q      <= cnt_d;
        end
    end

    assign i2sSD_o       = sd_q;
    assign i2sLRCLK_o    = lrclk_q;
    assign frameStrobe_o = strobe_q;
    assign underrun_o    = underrun_q;
    assign underrunCnt_o = cnt_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: one DUT resends on underrun, a twin sends zeros.
module tb_i2s_tx_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] pkt = 16'h0;
    logic        fifo_empty = 1'b1;

    logic        rd1, lr1, sd1, fs1, ur1;
    logic [7:0]  cnt1;
    logic        rd0, lr0, sd0, fs0, ur0;
    logic [7:0]  cnt0;

    logic [15:0] fifo_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] sd_v, sdz_v, lr_v, fs_v, rd_v, ur_v;

    localparam logic [31:0] LrExp = 32'h0001_FFFE;
    localparam logic [31:0] FsExp = 32'h8000_0000;

    always #5 clk = ~clk;

    i2s_tx_serializer #(.PKT_WIDTH(16), .SLOT_WIDTH(16), .UNDERRUN_HOLD(1)) u_dut_hold (
        .clkI2SBit_i(clk), .rstI2S_n_i(rst_n), .enable_i(enable), .pktFifo_i(pkt),
        .fifoEmpty_i(fifo_empty), .fifoRdEn_o(rd1), .i2sLRCLK_o(lr1), .i2sSD_o(sd1),
        .frameStrobe_o(fs1), .underrun_o(ur1), .underrunCnt_o(cnt1)
    );

    i2s_tx_serializer #(.PKT_WIDTH(16), .SLOT_WIDTH(16), .UNDERRUN_HOLD(0)) u_dut_zero (
        .clkI2SBit_i(clk), .rstI2S_n_i(rst_n), .enable_i(enable), .pktFifo_i(pkt),
        .fifoEmpty_i(fifo_empty), .fifoRdEn_o(rd0), .i2sLRCLK_o(lr0), .i2sSD_o(sd0),
        .frameStrobe_o(fs0), .underrun_o(ur0), .underrunCnt_o(cnt0)
    );

    // One bit-clock cycle: inputs change at the falling edge, outputs are sampled 1 ns later,
    // and the FIFO model pops when the read strobe is seen before the closing rising edge.
    task automatic cycle(input logic en);
        @(negedge clk);
        enable     = en;
        fifo_empty = (fifo_q.size() == 0);
        pkt        = fifo_empty ? 16'h0 : fifo_q[0];
        #1;
        if (rd1) void'(fifo_q.pop_front());
    endtask

    // 32 cycles of a frame; enable stays high for the first en_cycles of them.
    task automatic run_frame(input int en_cycles);
        sd_v = '0; sdz_v = '0; lr_v = '0; fs_v = '0; rd_v = '0; ur_v = '0;
        for (int i = 0; i < 32; i++) begin
            cycle(i < en_cycles);
            sd_v  = {sd_v[30:0], sd1};
            sdz_v = {sdz_v[30:0], sd0};
            lr_v  = {lr_v[30:0], lr1};
            fs_v  = {fs_v[30:0], fs1};
            rd_v  = {rd_v[30:0], rd1};
            ur_v  = {ur_v[30:0], ur1};
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        fifo_q.push_back(16'h1111);
        cycle(1'b1);
        cycle(1'b1);
        checks++;
        if ({sd1, lr1, fs1, ur1, rd1} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got sd/lr/fs/ur/rd=%b, expected 00000",
                     {sd1, lr1, fs1, ur1, rd1});
        end
        checks++;
        if (cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, expected 0", cnt1);
        end
        fifo_q.delete();
        enable = 1'b0;
        rst_n  = 1'b1;
        cycle(1'b0);
        checks++;
        if ({sd1, lr1, fs1, rd1} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got sd/lr/fs/rd=%b, expected 0000",
                     {sd1, lr1, fs1, rd1});
        end
    endtask

    task automatic test_first_frame;
        fifo_q.push_back(16'hA5C3);
        cycle(1'b1);
        checks++;
        if (rd1 !== 1'b1) begin
            errors++;
            $display("FAIL first_pop: got rd=%b, expected 1", rd1);
        end
        run_frame(31);
        checks++;
        if (sd_v !== {16'hA5C3, 16'hA5C3}) begin
            errors++;
            $display("FAIL first_sd: got %h, expected a5c3a5c3", sd_v);
        end
        checks++;
        if (lr_v !== LrExp) begin
            errors++;
            $display("FAIL first_lrclk: got %h, expected %h", lr_v, LrExp);
        end
        checks++;
        if (fs_v !== FsExp) begin
            errors++;
            $display("FAIL first_strobe: got %h, expected %h", fs_v, FsExp);
        end
        checks++;
        if (rd_v !== 32'h0) begin
            errors++;
            $display("FAIL first_single_pop: got rd pattern %h, expected 0", rd_v);
        end
    endtask

    task automatic test_continuous;
        logic [15:0] words[3];
        words[0] = 16'h8000; words[1] = 16'h0001; words[2] = 16'hFFFF;
        for (int i = 0; i < 3; i++) fifo_q.push_back(words[i]);
        cycle(1'b1);
        for (int i = 0; i < 3; i++) begin
            run_frame(i == 2 ? 31 : 32);
            checks++;
            if (sd_v !== {words[i], words[i]}) begin
                errors++;
                $display("FAIL cont_sd_%0d: got %h, expected %h", i, sd_v, {words[i], words[i]});
            end
            checks++;
            if (rd_v !== ((i == 2) ? 32'h0 : 32'h1)) begin
                errors++;
                $display("FAIL cont_pop_%0d: got rd pattern %h", i, rd_v);
            end
            checks++;
            if (ur_v !== 32'h0) begin
                errors++;
                $display("FAIL cont_underrun_%0d: got %h, expected 0", i, ur_v);
            end
        end
    endtask

    task automatic test_underrun;
        fifo_q.push_back(16'h1234);
        cycle(1'b1);
        run_frame(32);
        checks++;
        if (sd_v !== 32'h1234_1234 || sdz_v !== 32'h1234_1234) begin
            errors++;
            $display("FAIL ur_base_sd: got hold=%h zero=%h, expected 12341234", sd_v, sdz_v);
        end
        for (int f = 0; f < 2; f++) begin
            run_frame(f == 1 ? 31 : 32);
            checks++;
            if (sd_v !== 32'h1234_1234) begin
                errors++;
                $display("FAIL ur_hold_sd_%0d: got %h, expected 12341234", f, sd_v);
            end
            checks++;
            if (sdz_v !== 32'h0) begin
                errors++;
                $display("FAIL ur_zero_sd_%0d: got %h, expected 0", f, sdz_v);
            end
            checks++;
            if (ur_v !== FsExp) begin
                errors++;
                $display("FAIL ur_pulse_%0d: got %h, expected %h", f, ur_v, FsExp);
            end
        end
        checks++;
        if (cnt1 !== 8'd2 || cnt0 !== 8'd2) begin
            errors++;
            $display("FAIL ur_count: got hold=%0d zero=%0d, expected 2", cnt1, cnt0);
        end
    endtask

    task automatic test_saturation;
        cycle(1'b1);
        for (int f = 0; f < 299; f++) run_frame(f == 298 ? 31 : 32);
        checks++;
        if (cnt1 !== 8'd255 || cnt0 !== 8'd255) begin
            errors++;
            $display("FAIL sat_count: got hold=%0d zero=%0d, expected 255", cnt1, cnt0);
        end
        checks++;
        if (ur_v !== FsExp) begin
            errors++;
            $display("FAIL sat_pulse: got %h, expected %h", ur_v, FsExp);
        end
        checks++;
        if (sd_v !== 32'h1234_1234 || sdz_v !== 32'h0) begin
            errors++;
            $display("FAIL sat_sd: got hold=%h zero=%h", sd_v, sdz_v);
        end
    endtask

    task automatic test_enable_drop;
        fifo_q.push_back(16'h5A5A);
        fifo_q.push_back(16'h3C3C);
        cycle(1'b1);
        run_frame(10);
        checks++;
        if (sd_v !== 32'h5A5A_5A5A || lr_v !== LrExp) begin
            errors++;
            $display("FAIL drop_frame: got sd=%h lr=%h, expected 5a5a5a5a %h", sd_v, lr_v, LrExp);
        end
        checks++;
        if (rd_v !== 32'h0 || fifo_q.size() != 1) begin
            errors++;
            $display("FAIL drop_no_pop: got rd pattern %h, fifo level %0d, expected 0 and 1",
                     rd_v, fifo_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0);
            checks++;
            if ({sd1, lr1, fs1, rd1} !== 4'b0) begin
                errors++;
                $display("FAIL drop_idle_%0d: got sd/lr/fs/rd=%b, expected 0000", i,
                         {sd1, lr1, fs1, rd1});
            end
        end
        cycle(1'b1);
        checks++;
        if (rd1 !== 1'b1) begin
            errors++;
            $display("FAIL reenable_pop: got rd=%b, expected 1", rd1);
        end
        run_frame(31);
        checks++;
        if (sd_v !== 32'h3C3C_3C3C || fs_v !== FsExp) begin
            errors++;
            $display("FAIL reenable_frame: got sd=%h fs=%h, expected 3c3c3c3c %h", sd_v, fs_v,
                     FsExp);
        end
    endtask

    task automatic test_midframe_reset;
        fifo_q.push_back(16'hBEEF);
        cycle(1'b1);
        for (int i = 0; i <= 20; i++) cycle(1'b1);
        checks++;
        if (lr1 !== 1'b1 || cnt1 !== 8'd255) begin
            errors++;
            $display("FAIL pre_reset_state: got lr=%b cnt=%0d, expected 1 and 255", lr1, cnt1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sd1, lr1, fs1, ur1, rd1, sd0, lr0} !== 7'b0 || cnt1 !== 8'd0 || cnt0 !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got sd/lr/fs/ur/rd=%b cnt=%0d, expected zeros",
                     {sd1, lr1, fs1, ur1, rd1}, cnt1);
        end
        fifo_q.delete();
        fifo_q.push_back(16'h00FF);
        cycle(1'b1);
        enable = 1'b0;
        rst_n  = 1'b1;
        cycle(1'b1);
        checks++;
        if (rd1 !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_pop: got rd=%b, expected 1", rd1);
        end
        run_frame(31);
        checks++;
        if (sd_v !== 32'h00FF_00FF || fs_v !== FsExp || ur_v !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_frame: got sd=%h fs=%h ur=%h, expected 00ff00ff %h 0",
                     sd_v, fs_v, ur_v, FsExp);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_continuous();
        test_underrun();
        test_saturation();
        test_enable_drop();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
